cb_config_loader: RTL and testbench
===================================

CB_CONFIG_LOADER -- requirements
Module: cb_config_loader

Interface
REQ-001 Parameter NUM_CB, default 4: number of connection boxes configured per load (≥1).
REQ-002 Parameter CFG_W, default 35: configuration frame width per connection box.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a full load.
REQ-006 bit_valid  input  1  serial config bit present on bit_data.
REQ-007 bit_data  input  1  serial config bit, frame LSB first, box 0 first.
REQ-008 bit_ready  output  1  loader accepts a bit this cycle; transfer = bit_valid & bit_ready.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a legal load has been committed.
REQ-011 error  output  1  sticky: the last load was aborted on an illegal frame.
REQ-012 err_index  output  clog2(NUM_CB) (min 1)  index of the offending box; valid while error=1.
REQ-013 sram_bus  output  NUM_CB*CFG_W  committed config; box k occupies bits [k*CFG_W +: CFG_W], driving that box's sram_in.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, CHECK, COMMIT, DONE.
REQ-015 IDLE: bit_ready=0; start=1 -> SHIFT, bit counter=0, box index=0, error cleared, err_index cleared.
REQ-016 start SHALL be ignored in all states other than IDLE.
REQ-017 SHIFT: bit_ready=1; each transfer writes bit_data into frame[bit counter] and increments the counter; bit_valid low stalls indefinitely with no state change.
REQ-018 The transfer that delivers bit CFG_W-1 SHALL move the FSM to CHECK with the counter reset to 0.
REQ-019 CHECK (one cycle, bit_ready=0): the frame SHALL be illegal if (f[25]&f[26]&|f[4:0]), or if for any output group g=0..3 with enable bit e_g (f[27+2g] | f[28+2g]) set, more than one of select bits f[5+5g .. 9+5g] is set.
REQ-020 CHECK, legal frame: shadow[box index] <= frame; if box index = NUM_CB-1 -> COMMIT, else increment box index and go to SHIFT.
REQ-021 CHECK, illegal frame: error<=1, err_index<=box index, -> IDLE; sram_bus and shadows of earlier boxes SHALL NOT reach sram_bus.
REQ-022 COMMIT: sram_bus <= all shadows simultaneously in one cycle -> DONE.
REQ-023 DONE: done=1 for exactly this cycle, which is the first cycle the new sram_bus value is visible -> IDLE.
REQ-024 sram_bus SHALL hold its previous value throughout SHIFT and CHECK and on abort; partial configurations are never visible.
REQ-025 With bit_valid held high, done SHALL assert exactly (CFG_W+1)*NUM_CB+2 cycles after the cycle in which start is sampled (146 for defaults).
REQ-026 Bits offered while bit_ready=0 SHALL be neither consumed nor counted.

Reset
REQ-027 reset=1 SHALL force IDLE, counters 0, frame and shadows 0, sram_bus 0, bit_ready 0, busy 0, done 0, error 0, err_index 0.
REQ-028 reset has priority over start and bit transfers in the same cycle; reset mid-load discards all partial data.

Structure
REQ-029 Package cb_cfg_pkg SHALL hold the FSM state enum, CFG_W default, and field-position constants (track select 0-4, BLE drive enables 25/26, group selects 5-24, group enables 27-34).
REQ-030 The legality test of REQ-019 SHALL be a purely combinational sub-module cb_frame_checker (frame in, illegal out), reused by the bench's reference model.

Verification
REQ-031 Reset, then start; stream 140 legal bits (box k frame = bit 0 and bit 25 set, bit k+5 and bit 27 set), bit_valid held high -> done at cycle 146, sram_bus box k = 35'h0_0A00_0021 pattern per frame, error=0.
REQ-032 Same load with bit_valid toggled every other cycle -> identical sram_bus; done delayed by exactly 140 cycles; bit counter never advances on idle cycles.
REQ-033 Box 2 frame with bits 0, 25, 26 set -> error=1, err_index=2, FSM IDLE after its CHECK, sram_bus unchanged from prior load, no done.
REQ-034 Box 0 frame with bits 27, 5, 6 set -> error=1, err_index=0; following legal load clears error and commits.
REQ-035 Assert reset at bit 70 of a load -> next cycle sram_bus=0, busy=0, bit_ready=0; fresh load then completes normally.
REQ-036 start pulsed during SHIFT and again in DONE -> ignored; only one done pulse; bit counter unaffected.

Source files
------------

// File: rtl/cb_cfg_pkg.sv
// rtl/cb_cfg_pkg.sv - shared states and frame field positions for the connection-box config loader
package cb_cfg_pkg;

   localparam int CFG_W_DEF   = 35;

   localparam int TRK_SEL_LSB = 0;
   localparam int TRK_SEL_W   = 5;
   localparam int BLE_DRV_EN0 = 25;
   localparam int BLE_DRV_EN1 = 26;
   localparam int GRP_SEL_LSB = 5;
   localparam int GRP_SEL_W   = 5;
   localparam int GRP_EN_LSB  = 27;
   localparam int NUM_GRP     = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_COMMIT,
      ST_DONE
   } state_t;

   // v & (v-1) clears the lowest set bit, so anything left means two or more were set
   function automatic logic multi_hot(input logic [GRP_SEL_W-1:0] v);
      return |(v & (v - 1'b1));
   endfunction

endpackage

// File: rtl/cb_frame_checker.sv
// rtl/cb_frame_checker.sv - combinational legality test for one connection-box frame
module cb_frame_checker
   import cb_cfg_pkg::*;
#(
   parameter int CFG_W = CFG_W_DEF
) (
   input  logic [CFG_W-1:0] i_frame,
   output logic             o_illegal
);

   logic w_ble_clash;
   logic w_grp_clash;

   // Both BLE drivers enabled while a track select is active would short the track
   assign w_ble_clash = i_frame[BLE_DRV_EN0] & i_frame[BLE_DRV_EN1]
                      & (|i_frame[TRK_SEL_LSB +: TRK_SEL_W]);

   always_comb begin
      w_grp_clash = 1'b0;
      for (int g = 0; g < NUM_GRP; g++) begin
         if (i_frame[GRP_EN_LSB + 2*g] | i_frame[GRP_EN_LSB + 2*g + 1]) begin
            w_grp_clash = w_grp_clash
                        | multi_hot(i_frame[GRP_SEL_LSB + GRP_SEL_W*g +: GRP_SEL_W]);
         end
      end
   end

   assign o_illegal = w_ble_clash | w_grp_clash;

endmodule

// File: rtl/cb_config_loader.sv
// rtl/cb_config_loader.sv - serial loader that checks each box frame and commits all boxes atomically
module cb_config_loader
   import cb_cfg_pkg::*;
#(
   parameter  int NUM_CB = 4,
   parameter  int CFG_W  = CFG_W_DEF,
   localparam int IDX_W  = (NUM_CB > 1) ? $clog2(NUM_CB) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    bit_valid,
   input  logic                    bit_data,
   output logic                    bit_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [IDX_W-1:0]        err_index,
   output logic [NUM_CB*CFG_W-1:0] sram_bus
);

   localparam int               CNT_W    = (CFG_W > 1) ? $clog2(CFG_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);
   localparam logic [IDX_W-1:0] LAST_BOX = IDX_W'(NUM_CB - 1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CNT_W-1:0]          r_bit_cnt;
   logic [IDX_W-1:0]          r_box_idx;
   logic [CFG_W-1:0]          r_frame;
   logic [CFG_W-1:0]          r_shadow [NUM_CB];
   logic [NUM_CB*CFG_W-1:0]   r_sram;
   logic                      r_error;
   logic [IDX_W-1:0]          r_err_index;
   logic                      w_xfer;
   logic                      w_last_bit;
   logic                      w_illegal;

   cb_frame_checker #(.CFG_W(CFG_W)) u_checker (
      .i_frame   (r_frame),
      .o_illegal (w_illegal)
   );

   assign w_xfer     = bit_valid & bit_ready;
   assign w_last_bit = (r_bit_cnt == LAST_BIT);

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      bit_ready   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            bit_ready = 1'b1;
            if (bit_valid && w_last_bit) w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_illegal)               w_state_nxt = ST_IDLE;
            else if (r_box_idx == LAST_BOX) w_state_nxt = ST_COMMIT;
            else                         w_state_nxt = ST_SHIFT;
         end
         ST_COMMIT: w_state_nxt = ST_DONE;
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Frames land in shadows box by box; sram_bus only changes in COMMIT
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit_cnt   <= '0;
         r_box_idx   <= '0;
         r_frame     <= '0;
         r_sram      <= '0;
         r_error     <= 1'b0;
         r_err_index <= '0;
         for (int k = 0; k < NUM_CB; k++) r_shadow[k] <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bit_cnt   <= '0;
                  r_box_idx   <= '0;
                  r_error     <= 1'b0;
                  r_err_index <= '0;
               end
            end
            ST_SHIFT: begin
               if (w_xfer) begin
                  r_frame[r_bit_cnt] <= bit_data;
                  r_bit_cnt          <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               if (w_illegal) begin
                  r_error     <= 1'b1;
                  r_err_index <= r_box_idx;
               end else begin
                  r_shadow[r_box_idx] <= r_frame;
                  if (r_box_idx != LAST_BOX) r_box_idx <= r_box_idx + 1'b1;
               end
            end
            ST_COMMIT: begin
               for (int k = 0; k < NUM_CB; k++) r_sram[k*CFG_W +: CFG_W] <= r_shadow[k];
            end
            default: ;
         endcase
      end
   end

   assign sram_bus  = r_sram;
   assign error     = r_error;
   assign err_index = r_err_index;

endmodule

// File: tb/tb_cb_config_loader.sv
// tb/tb_cb_config_loader.sv - directed self-checking bench for cb_config_loader
module tb_cb_config_loader;

   localparam int NUM_CB = 4;
   localparam int CFG_W  = 35;
   localparam int NB     = NUM_CB * CFG_W;
   localparam int LIMIT  = 400;

   localparam logic [CFG_W-1:0] A0   = 35'h0_0A00_0021;
   localparam logic [CFG_W-1:0] A1   = 35'h0_0A00_0041;
   localparam logic [CFG_W-1:0] A2   = 35'h0_0A00_0081;
   localparam logic [CFG_W-1:0] A3   = 35'h0_0A00_0101;
   localparam logic [CFG_W-1:0] B0   = 35'h4_0010_0002;
   localparam logic [CFG_W-1:0] B1   = 35'h4_0020_0002;
   localparam logic [CFG_W-1:0] B2   = 35'h4_0040_0002;
   localparam logic [CFG_W-1:0] B3   = 35'h4_0080_0002;
   localparam logic [CFG_W-1:0] BAD2 = 35'h0_0600_0001;
   localparam logic [CFG_W-1:0] BAD0 = 35'h0_0800_0060;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            bit_valid;
   logic            bit_data;
   logic            bit_ready;
   logic            busy;
   logic            done;
   logic            error;
   logic [1:0]      err_index;
   logic [NB-1:0]   sram_bus;

   logic [CFG_W-1:0] chk_frame;
   logic             chk_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cb_config_loader #(.NUM_CB(NUM_CB), .CFG_W(CFG_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .bit_ready (bit_ready),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_index (err_index),
      .sram_bus  (sram_bus)
   );

   cb_frame_checker #(.CFG_W(CFG_W)) u_ref_chk (
      .i_frame   (chk_frame),
      .o_illegal (chk_illegal)
   );

   task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_frame(input logic [CFG_W-1:0] f, input logic exp_illegal, input string tag);
      chk_frame = f;
      #1;
      check(tag, NB'(chk_illegal), NB'(exp_illegal));
   endtask

   task automatic run_load(input logic [NB-1:0] stream, input bit gap, input int rst_bit,
                           input bit glitch, output int done_cyc, output int done_cnt,
                           output int end_cyc);
      int idx = 0;
      int cyc = 0;
      bit phase = 0;
      bit xfer;
      bit in_done = 0;
      bit glitched = 0;
      done_cyc = -1;
      done_cnt = 0;
      end_cyc  = -1;
      @(negedge clk);
      start     = 1'b1;
      bit_valid = !gap;
      bit_data  = stream[0];
      @(posedge clk);
      cyc = 1;
      #1 start = 1'b0;
      while (cyc < LIMIT) begin
         @(negedge clk);
         start = glitch && ((!glitched && idx == 50) || in_done);
         if (start && !in_done) glitched = 1;
         if (rst_bit >= 0 && idx == rst_bit) reset = 1'b1;
         bit_data = (idx < NB) ? stream[idx] : 1'b0;
         if (gap) begin
            bit_valid = bit_ready && phase;
            if (bit_ready) phase = !phase;
         end else begin
            bit_valid = 1'b1;
         end
         xfer = bit_valid && bit_ready;
         @(posedge clk);
         cyc++;
         if (xfer && !reset) idx++;
         #1;
         if (reset) begin
            end_cyc = cyc;
            break;
         end
         in_done = done;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (!busy) begin
            end_cyc = cyc;
            break;
         end
      end
      start     = 1'b0;
      bit_valid = 1'b0;
   endtask

   initial begin
      int dc, dn, ec;
      logic [NB-1:0] pat_a, pat_b;
      pat_a = {A3, A2, A1, A0};
      pat_b = {B3, B2, B1, B0};

      reset = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_data = 1'b1; chk_frame = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", NB'(busy), '0);
      check("rst_done", NB'(done), '0);
      check("rst_error", NB'(error), '0);
      check("rst_err_index", NB'(err_index), '0);
      check("rst_bit_ready", NB'(bit_ready), '0);
      check("rst_sram", sram_bus, '0);
      reset = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;

      check_frame(A0, 1'b0, "chk_legal_a0");
      check_frame(BAD2, 1'b1, "chk_ble_clash");
      check_frame(35'h0_0600_0000, 1'b0, "chk_ble_no_track");
      check_frame(35'h0_0000_0060, 1'b0, "chk_grp_disabled");
      check_frame(35'h0_1000_0060, 1'b1, "chk_grp0_en_hi");
      check_frame(35'h4_0180_0000, 1'b1, "chk_grp3_clash");
      check_frame(BAD0, 1'b1, "chk_bad0");

      run_load(pat_a, 0, -1, 0, dc, dn, ec);
      check("a_done_cycle", NB'(dc), NB'(146));
      check("a_done_count", NB'(dn), NB'(1));
      check("a_sram", sram_bus, pat_a);
      check("a_error", NB'(error), '0);

      run_load(pat_b, 0, -1, 0, dc, dn, ec);
      check("b_done_cycle", NB'(dc), NB'(146));
      check("b_sram", sram_bus, pat_b);

      run_load(pat_a, 1, -1, 0, dc, dn, ec);
      check("gap_done_cycle", NB'(dc), NB'(286));
      check("gap_done_count", NB'(dn), NB'(1));
      check("gap_sram", sram_bus, pat_a);

      run_load({A3, BAD2, A1, A0}, 0, -1, 0, dc, dn, ec);
      check("bad2_end_cycle", NB'(ec), NB'(109));
      check("bad2_done_count", NB'(dn), '0);
      check("bad2_error", NB'(error), NB'(1));
      check("bad2_err_index", NB'(err_index), NB'(2));
      check("bad2_sram_kept", sram_bus, pat_a);

      run_load({A3, A2, A1, BAD0}, 0, -1, 0, dc, dn, ec);
      check("bad0_end_cycle", NB'(ec), NB'(37));
      check("bad0_error", NB'(error), NB'(1));
      check("bad0_err_index", NB'(err_index), '0);
      check("bad0_sram_kept", sram_bus, pat_a);

      run_load(pat_b, 0, -1, 1, dc, dn, ec);
      check("glitch_done_cycle", NB'(dc), NB'(146));
      check("glitch_done_count", NB'(dn), NB'(1));
      check("glitch_error_clr", NB'(error), '0);
      check("glitch_sram", sram_bus, pat_b);
      @(negedge clk);
      check("glitch_idle_after", NB'(busy), '0);

      run_load(pat_a, 0, 70, 0, dc, dn, ec);
      check("midrst_sram", sram_bus, '0);
      check("midrst_busy", NB'(busy), '0);
      check("midrst_bit_ready", NB'(bit_ready), '0);
      check("midrst_done_count", NB'(dn), '0);
      @(negedge clk);
      reset = 1'b0;

      run_load(pat_a, 0, -1, 0, dc, dn, ec);
      check("fresh_done_cycle", NB'(dc), NB'(146));
      check("fresh_sram", sram_bus, pat_a);
      check("fresh_error", NB'(error), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
